ir_key_queue: RTL and testbench

- Downstream stage of the NEC IR frame decoder.
- Accepts each verified 8-bit command byte, with its one-cycle accept strobe, in the CLOCK_50 domain.
- Classifies each byte as a new press or a held-key repeat, suppresses the first repeats, and detects key release by timeout.
- Queues key events in a small FIFO with a valid/ready interface for the menu/display logic.

---
 rtl/ir_key_queue.sv | 152 +++++++++++++++
 tb/tb_ir_key_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_key_queue.sv
// NEC IR key event stage: classifies decoded command bytes as presses or held-key
// repeats, detects release by timeout, and queues events in a show-ahead FIFO.
module ir_key_queue #(
    parameter int HOLD_CYCLES = 6000000,
    parameter int REPEAT_SKIP = 3,
    parameter int DEPTH       = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [7:0] CODE_IN,
    input  logic       CODE_VALID,
    output logic [7:0] KEY_CODE,
    output logic       KEY_REPEAT,
    output logic       KEY_VALID,
    input  logic       KEY_READY,
    output logic       KEY_RELEASE,
    output logic       OVERFLOW,
    input  logic       OVF_CLR
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [TW-1:0] TIMER_MAX  = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [3:0]    SKIP       = 4'(REPEAT_SKIP);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {IDLE, HELD} state_t;

    state_t        state;
    logic [7:0]    last_code;
    logic [3:0]    rep_cnt;
    logic [TW-1:0] timer;
    logic          release_reg;

    logic          new_press;
    logic          push_req;
    logic          push_rep;

    always_comb begin
        new_press = CODE_VALID && ((state == IDLE) || (CODE_IN != last_code));
        push_req  = new_press || (CODE_VALID && (rep_cnt >= SKIP));
        push_rep  = !new_press;
    end

    // A frame arriving in the expiry cycle takes priority over the timeout.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            last_code   <= 8'd0;
            rep_cnt     <= 4'd0;
            timer       <= '0;
            release_reg <= 1'b0;
        end else begin
            release_reg <= 1'b0;
            if (CODE_VALID) begin
                timer <= '0;
                state <= HELD;
                if (new_press) begin
                    last_code <= CODE_IN;
                    rep_cnt   <= 4'd0;
                end else if (rep_cnt < SKIP) begin
                    rep_cnt <= rep_cnt + 4'd1;
                end
            end else if (state == HELD) begin
                if (timer == TIMER_LAST) begin
                    timer       <= TIMER_MAX;
                    state       <= IDLE;
                    release_reg <= 1'b1;
                end else if (timer != TIMER_MAX) begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

    assign KEY_RELEASE = release_reg;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [8:0]    head_reg;
    logic [8:0]    push_data;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;
    logic          ovf_reg;

    always_comb begin
        push_data = {push_rep, CODE_IN};
        full      = (count == FULL_COUNT);
        do_pop    = KEY_VALID && KEY_READY;
        do_push   = push_req && (!full || do_pop);
        drop      = push_req && full && !do_pop;
    end

    assign KEY_VALID  = (count != '0);
    assign KEY_CODE   = head_reg[7:0];
    assign KEY_REPEAT = head_reg[8];
    assign OVERFLOW   = ovf_reg;

    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The head register is the show-ahead output; it is refreshed from storage
    // on a pop, or loaded directly when an entry lands in an empty queue.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_reg <= 9'd0;
            ovf_reg  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (do_pop) begin
                if (count == CW'(1)) begin
                    if (do_push) begin
                        head_reg <= push_data;
                    end
                end else begin
                    head_reg <= mem[rd_ptr + AW'(1)];
                end
            end else if (!KEY_VALID && do_push) begin
                head_reg <= push_data;
            end
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (OVF_CLR) begin
                ovf_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ir_key_queue.sv
// Directed bench for ir_key_queue: cycle-level vector table plus timed frame sequences.
module tb_ir_key_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] code_in;
    logic       code_valid;
    logic [7:0] key_code;
    logic       key_repeat;
    logic       key_valid;
    logic       key_ready;
    logic       key_release;
    logic       overflow;
    logic       ovf_clr;

    ir_key_queue #(
        .HOLD_CYCLES(100),
        .REPEAT_SKIP(2),
        .DEPTH(4)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N(rst_n),
        .CODE_IN(code_in),
        .CODE_VALID(code_valid),
        .KEY_CODE(key_code),
        .KEY_REPEAT(key_repeat),
        .KEY_VALID(key_valid),
        .KEY_READY(key_ready),
        .KEY_RELEASE(key_release),
        .OVERFLOW(overflow),
        .OVF_CLR(ovf_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rel_cnt  = 0;
    int rel_cyc  = 0;
    int last_frame_cyc = 0;

    logic [8:0] pop_q[$];
    logic [8:0] exp_q[$];

    typedef struct packed {
        logic       cv;
        logic [7:0] code;
        logic       rdy;
        logic       clr;
        logic       exp_valid;
        logic [7:0] exp_code;
        logic       exp_rep;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe handshakes and release pulses mid-cycle, when inputs are stable.
    always @(negedge clk) begin
        if (rst_n && key_valid && key_ready) pop_q.push_back({key_repeat, key_code});
        if (key_release) begin
            rel_cnt = rel_cnt + 1;
            rel_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [7:0] c);
        code_valid = 1'b1;
        code_in    = c;
        tick(1);
        last_frame_cyc = cyc;
        code_valid = 1'b0;
        $display("frame code=%02h at cycle %0d", c, cyc);
    endtask

    task automatic cmp_pops(input string name);
        int n;
        check({name, "_count"}, pop_q.size(), exp_q.size());
        n = (pop_q.size() < exp_q.size()) ? pop_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_entry%0d", name, i), {23'd0, pop_q[i]}, {23'd0, exp_q[i]});
    endtask

    task automatic add(input logic cv, input logic [7:0] c, input logic rdy, input logic clr,
                       input logic ev, input logic [7:0] ec, input logic er, input logic eo);
        vec_t v;
        v.cv = cv; v.code = c; v.rdy = rdy; v.clr = clr;
        v.exp_valid = ev; v.exp_code = ec; v.exp_rep = er; v.exp_ovf = eo;
        vecs.push_back(v);
    endtask

    int rel0;

    initial begin
        rst_n = 1'b0; code_in = 8'd0; code_valid = 1'b0; key_ready = 1'b0; ovf_clr = 1'b0;
        #1;
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_repeat", key_repeat, 0);
        check("rst_release", key_release, 0);
        check("rst_ovf", overflow, 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single press and release timing
        key_ready = 1'b1;
        frame(8'h45);
        check("press_valid", key_valid, 1);
        check("press_code", key_code, 8'h45);
        check("press_repeat", key_repeat, 0);
        tick(99);
        check("press_no_early_release", key_release, 0);
        tick(1);
        check("press_release", key_release, 1);
        tick(1);
        check("press_release_1cyc", key_release, 0);

        // Hold with repeat suppression
        pop_q.delete(); rel0 = rel_cnt;
        frame(8'h45);
        for (int i = 0; i < 6; i++) begin
            tick(49);
            frame(8'h45);
        end
        tick(110);
        exp_q = '{9'h045, 9'h145, 9'h145, 9'h145, 9'h145};
        cmp_pops("hold");
        check("hold_release_cnt", rel_cnt, rel0 + 1);
        check("hold_release_delay", rel_cyc - last_frame_cyc, 100);

        // Key change without release
        pop_q.delete(); rel0 = rel_cnt;
        frame(8'h45);
        tick(29);
        frame(8'h46);
        tick(2);
        exp_q = '{9'h045, 9'h046};
        cmp_pops("change");
        check("change_no_release", rel_cnt, rel0);
        tick(110);
        check("change_release", rel_cnt, rel0 + 1);

        // Overflow with consumer stalled
        key_ready = 1'b0; rel0 = rel_cnt;
        for (int i = 0; i < 5; i++) begin
            frame(8'h10 + 8'(i));
            tick(149);
        end
        check("ovf_releases", rel_cnt, rel0 + 5);
        check("ovf_valid", key_valid, 1);
        check("ovf_head", key_code, 8'h10);
        check("ovf_flag", overflow, 1);
        pop_q.delete();
        key_ready = 1'b1;
        tick(6);
        exp_q = '{9'h010, 9'h011, 9'h012, 9'h013};
        cmp_pops("ovf_drain");
        check("ovf_drained_valid", key_valid, 0);
        check("ovf_hold_last_code", key_code, 8'h13);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Frame in the expiry cycle counts as repeat 1
        pop_q.delete(); rel0 = rel_cnt;
        frame(8'h45);
        tick(99);
        frame(8'h45);
        tick(2);
        check("expiry_no_release", rel_cnt, rel0);
        tick(47);
        frame(8'h45);
        tick(49);
        frame(8'h45);
        tick(2);
        exp_q = '{9'h045, 9'h145};
        cmp_pops("expiry");
        check("expiry_no_release2", rel_cnt, rel0);
        tick(110);
        check("expiry_final_release", rel_cnt, rel0 + 1);

        // Cycle-level FIFO vectors: full push+pop, single-entry push+pop, drop vs clear
        add(1, 8'h21, 0, 0, 1, 8'h21, 0, 0);
        add(1, 8'h22, 0, 0, 1, 8'h21, 0, 0);
        add(1, 8'h23, 0, 0, 1, 8'h21, 0, 0);
        add(1, 8'h24, 0, 0, 1, 8'h21, 0, 0);
        add(1, 8'h25, 1, 0, 1, 8'h22, 0, 0);
        add(0, 8'h00, 1, 0, 1, 8'h23, 0, 0);
        add(0, 8'h00, 1, 0, 1, 8'h24, 0, 0);
        add(0, 8'h00, 1, 0, 1, 8'h25, 0, 0);
        add(0, 8'h00, 1, 0, 0, 8'h25, 0, 0);
        add(1, 8'h26, 1, 0, 1, 8'h26, 0, 0);
        add(1, 8'h27, 1, 0, 1, 8'h27, 0, 0);
        add(1, 8'h27, 0, 0, 1, 8'h27, 0, 0);
        add(1, 8'h27, 0, 0, 1, 8'h27, 0, 0);
        add(1, 8'h27, 0, 0, 1, 8'h27, 0, 0);
        add(0, 8'h00, 1, 0, 1, 8'h27, 1, 0);
        add(0, 8'h00, 1, 0, 0, 8'h27, 1, 0);
        add(1, 8'h31, 0, 0, 1, 8'h31, 0, 0);
        add(1, 8'h32, 0, 0, 1, 8'h31, 0, 0);
        add(1, 8'h33, 0, 0, 1, 8'h31, 0, 0);
        add(1, 8'h34, 0, 0, 1, 8'h31, 0, 0);
        add(1, 8'h35, 0, 1, 1, 8'h31, 0, 1);
        add(0, 8'h00, 0, 1, 1, 8'h31, 0, 0);
        add(0, 8'h00, 1, 0, 1, 8'h32, 0, 0);
        add(0, 8'h00, 1, 0, 1, 8'h33, 0, 0);
        add(0, 8'h00, 1, 0, 1, 8'h34, 0, 0);
        add(0, 8'h00, 1, 0, 0, 8'h34, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            code_valid = vecs[i].cv;
            code_in    = vecs[i].code;
            key_ready  = vecs[i].rdy;
            ovf_clr    = vecs[i].clr;
            tick(1);
            $display("vec %0d: valid=%0b code=%02h rep=%0b ovf=%0b", i, key_valid, key_code, key_repeat, overflow);
            check($sformatf("vec%0d_valid", i), key_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_code", i), key_code, vecs[i].exp_code);
            check($sformatf("vec%0d_rep", i), key_repeat, vecs[i].exp_rep);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
            check($sformatf("vec%0d_release", i), key_release, 0);
        end
        code_valid = 1'b0; ovf_clr = 1'b0; key_ready = 1'b1;
        tick(110);

        // Reset while a key is held with two queued entries
        key_ready = 1'b0;
        frame(8'h45);
        frame(8'h45);
        frame(8'h45);
        frame(8'h45);
        tick(10);
        check("prereset_head", {key_repeat, key_code}, 9'h045);
        check("prereset_valid", key_valid, 1);
        rel0 = rel_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_valid", key_valid, 0);
        check("midreset_release", key_release, 0);
        tick(2);
        rst_n = 1'b1;
        tick(120);
        check("postreset_no_release", rel_cnt, rel0);
        check("postreset_empty", key_valid, 0);
        key_ready = 1'b1;
        frame(8'h45);
        check("postreset_valid", key_valid, 1);
        check("postreset_entry", {key_repeat, key_code}, 9'h045);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
